ysyx_24100029_regfile_sb: RTL and testbench
===========================================

YSYX_24100029_REGFILE_SB -- requirements
Module: ysyx_24100029_regfile_sb

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- XLEN, 32: data width.
- NREG, 32: register count, power of two, >=2.
- NRD, 2: read port count, 1..4.
- BYPASS, 1: 1 = same-cycle write forwarded to read ports.
REQ-002 SHALL derive AW = log2(NREG).
REQ-003 SHALL have ports (name, direction, width, meaning):
- clock, input, 1: sole clock; all state on posedge.
- reset, input, 1: asynchronous, active-low reset.
- rd_addr, input, NRD*AW: packed read addresses; port i at [i*AW +: AW].
- rd_data, output, NRD*XLEN: packed read data.
- rd_ready, output, NRD: 1 = read value final (no pending write).
- iss_valid, input, 1: issue request reserving destination iss_rd.
- iss_rd, input, AW: destination register of the issue.
- iss_ready, output, 1: issue accepted this cycle.
- wb_en, input, 1: writeback strobe.
- wb_addr, input, AW: writeback register.
- wb_data, input, XLEN: writeback data.
- flush, input, 1: discard all reservations.
- a0_value, output, XLEN: contents of register 10 (0 when NREG<=10).
- busy_cnt, output, AW+1: number of reserved registers.

Function
REQ-004 Register 0 SHALL always read 0; writes to it SHALL be ignored and issues to it SHALL never reserve.
REQ-005 Reads SHALL be combinational: rd_data[i] = rf[rd_addr[i]].
REQ-006 When BYPASS=1, wb_en=1, wb_addr=rd_addr[i] and wb_addr!=0, rd_data[i] SHALL equal wb_data in the same cycle.
REQ-007 Writes SHALL update rf at the next posedge; with BYPASS=0 the new value SHALL be readable from the following cycle.
REQ-008 Scoreboard: one busy bit per register. Accepted issue with iss_rd!=0 SHALL set busy[iss_rd] at the next edge.
REQ-009 wb_en with wb_addr!=0 SHALL clear busy[wb_addr] at the next edge.
REQ-010 Writeback to a non-busy register SHALL still update rf.
REQ-011 iss_ready SHALL be 1 iff flush=0 and (iss_rd==0 or busy[iss_rd]==0 or (wb_en and wb_addr==iss_rd)). Busy destination stalls (WAW protection).
REQ-012 Simultaneous writeback and accepted issue to the same rd SHALL write the data and leave busy set (issue wins).
REQ-013 rd_ready[i] SHALL be 1 iff busy[rd_addr[i]]==0, or BYPASS=1 and REQ-006 forwarding applies.
REQ-014 flush SHALL clear all busy bits at the next edge and block any issue that cycle (iss_ready=0). A coincident writeback SHALL still write rf.
REQ-015 busy_cnt SHALL equal the population count of busy bits, registered, and SHALL be consistent with busy in the same cycle.
REQ-016 Iss_valid=0 SHALL cause no state change from the issue port; iss_ready SHALL be valid regardless of iss_valid.

Reset
REQ-017 reset low SHALL asynchronously clear all rf entries to 0, all busy bits to 0 and busy_cnt to 0.
REQ-018 During reset: rd_data=0, rd_ready all 1, iss_ready=0, a0_value=0.
REQ-019 First state update SHALL occur on the first posedge after reset deasserts.
REQ-020 Reset mid-operation SHALL discard in-flight reservations; later writebacks to those registers SHALL be treated per REQ-010.

Structure
REQ-021 Package ysyx_24100029_rf_pkg SHALL hold the defaults XLEN_D, NREG_D, NRD_D and the A0_IDX=10 constant.
REQ-022 Busy-bit array, issue/flush arbitration and busy_cnt SHALL live in sub-module ysyx_24100029_scoreboard.
REQ-023 The top SHALL hold the data array and the bypass muxes.

Verification
REQ-024 Reset, then read all registers -> every rd_data=0; write x0=0xDEADBEEF -> x0 still reads 0.
REQ-025 wb x5=0x1234 while rd_addr[0]=5, BYPASS=1 -> rd_data[0]=0x1234 same cycle; with BYPASS=0 -> visible next cycle.
REQ-026 Issue x7, then issue x7 again -> second iss_ready=0 and busy_cnt=1; wb x7=0xAA -> rd_ready=1, busy_cnt=0, and the re-issue is accepted in the wb cycle.
REQ-027 Same-cycle wb x3=0x55 and issue x3 -> x3 reads 0x55 next cycle and busy[3] stays set (rd_ready=0).
REQ-028 Issue x1, x2, x4, then flush with coincident wb x9=0x9 -> busy_cnt=0, the issue that cycle is rejected, x9=0x9.
REQ-029 Reserve x10, write a0=0x77, then assert reset asynchronously between edges -> a0_value=0 immediately, busy_cnt=0.

Source files
------------

// File: rtl/ysyx_24100029_rf_pkg.sv
// Shared defaults for the scoreboarded register file.
// A0_IDX marks the ABI a0 register that is mirrored on a dedicated output.
package ysyx_24100029_rf_pkg;

   localparam int XLEN_D = 32;
   localparam int NREG_D = 32;
   localparam int NRD_D  = 2;
   localparam int A0_IDX = 10;

endpackage

// File: rtl/ysyx_24100029_scoreboard.sv
// Per-register busy bits with issue/flush arbitration and a registered popcount.
// Register 0 can never be reserved, so busy[0] is pinned low.
module ysyx_24100029_scoreboard
   import ysyx_24100029_rf_pkg::*;
#(
   parameter  int NREG = NREG_D,
   localparam int AW   = $clog2(NREG)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_rd,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   input  logic            flush,
   output logic            iss_ready,
   output logic [NREG-1:0] busy,
   output logic [AW:0]     busy_cnt
);

   logic [NREG-1:0] busy_next;
   logic [AW:0]     cnt_next;

   // A busy destination only stalls when this cycle's writeback is not releasing it.
   always_comb begin
      iss_ready = reset && !flush &&
                  ((iss_rd == '0) || !busy[iss_rd] || (wb_en && (wb_addr == iss_rd)));
   end

   // Issue is applied after the writeback clear so a same-register collision stays reserved.
   always_comb begin
      busy_next = busy;
      if (flush) begin
         busy_next = '0;
      end else begin
         if (wb_en) begin
            busy_next[wb_addr] = 1'b0;
         end
         if (iss_valid && iss_ready) begin
            busy_next[iss_rd] = 1'b1;
         end
      end
      busy_next[0] = 1'b0;
   end

   always_comb begin
      cnt_next = '0;
      for (int r = 0; r < NREG; r++) begin
         cnt_next = cnt_next + (AW+1)'(busy_next[r]);
      end
   end

   // The count is registered from the same next-state vector, keeping it in lockstep with busy.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_next;
         busy_cnt <= cnt_next;
      end
   end

endmodule

// File: rtl/ysyx_24100029_regfile_sb.sv
// Multi-port register file with optional write-to-read bypass and a WAW scoreboard.
// Register 0 is hardwired to zero; reset is asynchronous and active-low.
module ysyx_24100029_regfile_sb
   import ysyx_24100029_rf_pkg::*;
#(
   parameter  int XLEN   = XLEN_D,
   parameter  int NREG   = NREG_D,
   parameter  int NRD    = NRD_D,
   parameter  int BYPASS = 1,
   localparam int AW     = $clog2(NREG)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]    rd_ready,
   input  logic              iss_valid,
   input  logic [AW-1:0]     iss_rd,
   output logic              iss_ready,
   input  logic              wb_en,
   input  logic [AW-1:0]     wb_addr,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              flush,
   output logic [XLEN-1:0]   a0_value,
   output logic [AW:0]       busy_cnt
);

   logic [XLEN-1:0] rf [NREG];
   logic [NREG-1:0] busy;

   ysyx_24100029_scoreboard #(
      .NREG (NREG)
   ) u_scoreboard (
      .clock     (clock),
      .reset     (reset),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .flush     (flush),
      .iss_ready (iss_ready),
      .busy      (busy),
      .busy_cnt  (busy_cnt)
   );

   // Entry 0 is never written, so it keeps its reset value of zero forever.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < NREG; r++) begin
            rf[r] <= '0;
         end
      end else if (wb_en && (wb_addr != '0)) begin
         rf[wb_addr] <= wb_data;
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] ra;
      logic          fwd;

      // Forwarding is gated by reset so the read ports show zero while reset is held.
      assign ra  = rd_addr[i*AW +: AW];
      assign fwd = (BYPASS != 0) && reset && wb_en && (wb_addr == ra) && (wb_addr != '0);
      assign rd_data[i*XLEN +: XLEN] = fwd ? wb_data : rf[ra];
      assign rd_ready[i] = !busy[ra] || fwd;
   end

   if (NREG > A0_IDX) begin : g_a0
      localparam logic [AW-1:0] A0_ADDR = AW'(A0_IDX);
      assign a0_value = rf[A0_ADDR];
   end else begin : g_no_a0
      assign a0_value = '0;
   end

endmodule

// File: tb/tb_ysyx_24100029_regfile_sb.sv
// Directed bench for the scoreboarded register file: a bypassing and a non-bypassing
// instance share stimulus and are compared every cycle against an architectural model.
module tb_ysyx_24100029_regfile_sb;

   logic        clock;
   logic        reset;
   logic [9:0]  rd_addr;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flush;

   logic [63:0] rd_data_a, rd_data_b;
   logic [1:0]  rd_ready_a, rd_ready_b;
   logic        iss_ready_a, iss_ready_b;
   logic [31:0] a0_a, a0_b;
   logic [5:0]  busy_cnt_a, busy_cnt_b;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 0;

   logic [31:0] m_rf [32];
   bit          m_busy [32];

   ysyx_24100029_regfile_sb #(.BYPASS(1)) dut_a (
      .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a),
      .rd_ready(rd_ready_a), .iss_valid(iss_valid), .iss_rd(iss_rd),
      .iss_ready(iss_ready_a), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .flush(flush), .a0_value(a0_a), .busy_cnt(busy_cnt_a)
   );

   ysyx_24100029_regfile_sb #(.BYPASS(0)) dut_b (
      .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
      .rd_ready(rd_ready_b), .iss_valid(iss_valid), .iss_rd(iss_rd),
      .iss_ready(iss_ready_b), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .flush(flush), .a0_value(a0_b), .busy_cnt(busy_cnt_b)
   );

   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic bit m_iss_ready();
      return reset && !flush &&
             ((iss_rd == 0) || !m_busy[iss_rd] || (wb_en && (wb_addr == iss_rd)));
   endfunction

   function automatic int m_busy_count();
      int n = 0;
      for (int r = 0; r < 32; r++) n += int'(m_busy[r]);
      return n;
   endfunction

   function automatic bit m_fwd(input int port, input bit byp);
      logic [4:0] ra = rd_addr[port*5 +: 5];
      return byp && reset && wb_en && (wb_addr == ra) && (ra != 0);
   endfunction

   function automatic logic [31:0] m_data(input int port, input bit byp);
      logic [4:0] ra = rd_addr[port*5 +: 5];
      if (!reset) return 32'h0;
      if (m_fwd(port, byp)) return wb_data;
      return (ra == 0) ? 32'h0 : m_rf[ra];
   endfunction

   function automatic bit m_ready(input int port, input bit byp);
      logic [4:0] ra = rd_addr[port*5 +: 5];
      if (!reset) return 1'b1;
      return !m_busy[ra] || m_fwd(port, byp);
   endfunction

   // Architectural state: writes land at the edge, flush wipes reservations, issue beats writeback.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < 32; r++) begin
            m_rf[r]   = 32'h0;
            m_busy[r] = 1'b0;
         end
      end else begin
         bit accept;
         accept = iss_valid && m_iss_ready();
         if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
         if (flush) begin
            for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
         end else begin
            if (wb_en && wb_addr != 0) m_busy[wb_addr] = 1'b0;
            if (accept && iss_rd != 0) m_busy[iss_rd] = 1'b1;
         end
      end
   end

   always @(negedge clock) begin
      if (cmp_en) begin
         for (int p = 0; p < 2; p++) begin
            checkOutput($sformatf("rd_data%0d_a", p), rd_data_a[p*32 +: 32], m_data(p, 1));
            checkOutput($sformatf("rd_data%0d_b", p), rd_data_b[p*32 +: 32], m_data(p, 0));
            checkOutput($sformatf("rd_ready%0d_a", p), rd_ready_a[p], m_ready(p, 1));
            checkOutput($sformatf("rd_ready%0d_b", p), rd_ready_b[p], m_ready(p, 0));
         end
         checkOutput("iss_ready_a", iss_ready_a, m_iss_ready());
         checkOutput("iss_ready_b", iss_ready_b, m_iss_ready());
         checkOutput("a0_a", a0_a, m_rf[10]);
         checkOutput("a0_b", a0_b, m_rf[10]);
         checkOutput("busy_cnt_a", busy_cnt_a, m_busy_count());
         checkOutput("busy_cnt_b", busy_cnt_b, m_busy_count());
      end
   end

   task automatic applyStimulus(input logic [4:0] ra0, input logic [4:0] ra1, input logic iv,
                                input logic [4:0] ird, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic fl);
      rd_addr   = {ra1, ra0};
      iss_valid = iv;
      iss_rd    = ird;
      wb_en     = we;
      wb_addr   = wa;
      wb_data   = wd;
      flush     = fl;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      reset = 1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      #1 reset = 0;
      cmp_en = 1;

      // Reset holds outputs quiet even with traffic on the ports
      applyStimulus(5, 5, 1, 3, 1, 5, 32'h1234, 0);
      settle();
      checkOutput("rst_rd_data", rd_data_a, 64'h0);
      checkOutput("rst_rd_ready", rd_ready_a, 2'b11);
      checkOutput("rst_iss_ready", iss_ready_a, 1'b0);
      checkOutput("rst_a0", a0_b, 32'h0);
      tick();
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1;

      for (int i = 0; i < 16; i++) begin
         applyStimulus(5'(i), 5'(31 - i), 0, 0, 0, 0, 0, 0);
         tick();
      end
      applyStimulus(10, 31, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("all_zero", rd_data_b, 64'h0);

      // x0 ignores writes and never forwards
      applyStimulus(0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0);
      settle();
      checkOutput("x0_nofwd", rd_data_a[31:0], 32'h0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("x0_zero", rd_data_b[31:0], 32'h0);
      tick();

      applyStimulus(5, 0, 0, 0, 1, 5, 32'h1234, 0);
      settle();
      checkOutput("x5_bypass", rd_data_a[31:0], 32'h1234);
      checkOutput("x5_nobypass", rd_data_b[31:0], 32'h0);
      tick();
      applyStimulus(5, 0, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("x5_next", rd_data_b[31:0], 32'h1234);
      tick();

      // WAW stall on x7, release by writeback, re-issue accepted in the writeback cycle
      applyStimulus(7, 0, 1, 7, 0, 0, 0, 0);
      settle();
      checkOutput("iss7_first", iss_ready_a, 1'b1);
      tick();
      applyStimulus(7, 0, 1, 7, 0, 0, 0, 0);
      settle();
      checkOutput("iss7_stall", iss_ready_a, 1'b0);
      checkOutput("iss7_cnt", busy_cnt_a, 6'd1);
      checkOutput("x7_notready", rd_ready_b[0], 1'b0);
      tick();
      applyStimulus(7, 0, 0, 0, 1, 7, 32'hAA, 0);
      settle();
      checkOutput("x7_fwd_ready", rd_ready_a[0], 1'b1);
      checkOutput("x7_fwd_data", rd_data_a[31:0], 32'hAA);
      checkOutput("x7_nofwd_ready", rd_ready_b[0], 1'b0);
      tick();
      applyStimulus(7, 0, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("x7_cnt_clear", busy_cnt_a, 6'd0);
      checkOutput("x7_ready", rd_ready_b, 2'b11);
      checkOutput("x7_data", rd_data_b[31:0], 32'hAA);
      tick();
      applyStimulus(7, 0, 1, 7, 0, 0, 0, 0);
      tick();
      applyStimulus(7, 0, 1, 7, 1, 7, 32'hBB, 0);
      settle();
      checkOutput("iss7_wb_accept", iss_ready_b, 1'b1);
      tick();
      applyStimulus(7, 0, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("x7_still_busy", busy_cnt_a, 6'd1);
      checkOutput("x7_bb", rd_data_b[31:0], 32'hBB);
      checkOutput("x7_bb_ready", rd_ready_a[0], 1'b0);
      tick();
      applyStimulus(7, 0, 0, 0, 1, 7, 32'hCC, 0);
      tick();

      applyStimulus(3, 0, 1, 3, 1, 3, 32'h55, 0);
      settle();
      checkOutput("iss3_ready", iss_ready_a, 1'b1);
      tick();
      applyStimulus(3, 0, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("x3_data", rd_data_a[31:0], 32'h55);
      checkOutput("x3_busy", rd_ready_a[0], 1'b0);
      checkOutput("x3_cnt", busy_cnt_b, 6'd1);
      tick();
      applyStimulus(3, 0, 0, 0, 1, 3, 32'h66, 0);
      tick();

      // Flush with a coincident writeback and a rejected issue
      applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 1, 2, 0, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 1, 4, 0, 0, 0, 0);
      tick();
      applyStimulus(9, 6, 1, 6, 1, 9, 32'h9, 1);
      settle();
      checkOutput("flush_iss", iss_ready_a, 1'b0);
      checkOutput("flush_cnt_before", busy_cnt_a, 6'd3);
      checkOutput("flush_x9_fwd", rd_data_a[31:0], 32'h9);
      tick();
      applyStimulus(9, 6, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("flush_cnt", busy_cnt_b, 6'd0);
      checkOutput("flush_x9", rd_data_b[31:0], 32'h9);
      checkOutput("flush_ready", rd_ready_b, 2'b11);
      tick();

      applyStimulus(0, 0, 1, 12, 0, 0, 0, 0);
      tick();
      applyStimulus(12, 12, 0, 0, 1, 12, 32'hC0FFEE, 0);
      settle();
      checkOutput("x12_ready_a", rd_ready_a, 2'b11);
      checkOutput("x12_ready_b", rd_ready_b, 2'b00);
      tick();

      applyStimulus(13, 0, 0, 13, 0, 0, 0, 0);
      settle();
      checkOutput("noval_ready", iss_ready_a, 1'b1);
      tick();
      applyStimulus(13, 0, 1, 0, 0, 0, 0, 0);
      settle();
      checkOutput("noval_cnt", busy_cnt_a, 6'd0);
      checkOutput("iss0_ready", iss_ready_b, 1'b1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("iss0_cnt", busy_cnt_b, 6'd0);
      tick();

      // Asynchronous reset between edges with a live reservation and a0 written
      applyStimulus(10, 0, 1, 10, 0, 0, 0, 0);
      tick();
      applyStimulus(10, 11, 1, 11, 1, 10, 32'h77, 0);
      tick();
      applyStimulus(10, 11, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("a0_set", a0_a, 32'h77);
      checkOutput("a0_cnt", busy_cnt_a, 6'd1);
      tick();
      applyStimulus(10, 11, 1, 5, 0, 0, 0, 0);
      #1 reset = 0;
      #1;
      checkOutput("arst_a0", a0_a, 32'h0);
      checkOutput("arst_cnt", busy_cnt_a, 6'd0);
      checkOutput("arst_ready", rd_ready_b, 2'b11);
      checkOutput("arst_iss", iss_ready_a, 1'b0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      reset = 1;
      applyStimulus(11, 0, 0, 0, 1, 11, 32'h5, 0);
      tick();
      applyStimulus(11, 0, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("post_rst_x11", rd_data_b[31:0], 32'h5);
      checkOutput("post_rst_cnt", busy_cnt_b, 6'd0);
      checkOutput("post_rst_ready", rd_ready_b, 2'b11);
      tick();
      tick();

      cmp_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
